// File: rtl/if_pkg.sv
// if_pkg: shared constants, redirect encodings and FSM states for the fetch unit
package if_pkg;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
  localparam int IM_WORDS_DEF = 1024;
  localparam logic [1:0] RK_BRANCH = 2'b00;
  localparam logic [1:0] RK_JUMP = 2'b01;
  localparam logic [1:0] RK_REG = 2'b10;
  typedef enum logic [1:0] {S_RUN, S_HALTED, S_FAULT} state_e;
endpackage

// File: rtl/if_next_pc.sv
// if_next_pc: selects the sequential or redirect next-PC and flags it illegal
module if_next_pc
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int IM_WORDS = IM_WORDS_DEF
) (
  input  logic [31:0] pc,
  input  logic        redirect_valid,
  input  logic [1:0]  redirect_kind,
  input  logic [31:0] redirect_base,
  input  logic [25:0] redirect_imm,
  input  logic [31:0] redirect_reg,
  output logic [31:0] next_pc,
  output logic        illegal
);
  localparam logic [31:0] HI_PC = RESET_PC + 32'(IM_WORDS) * 32'd4 - 32'd4;
  logic [31:0] base4, br_tgt, jmp_tgt;
  always_comb begin
    base4 = redirect_base + 32'd4;
    br_tgt = base4 + {{14{redirect_imm[15]}}, redirect_imm[15:0], 2'b00};
    jmp_tgt = {base4[31:28], redirect_imm, 2'b00};
    next_pc = !redirect_valid ? pc + 32'd4 :
              redirect_kind == RK_BRANCH ? br_tgt :
              redirect_kind == RK_JUMP ? jmp_tgt : redirect_reg;
    illegal = (redirect_valid && redirect_kind == 2'b11) || next_pc[1:0] != 2'b00 ||
              next_pc < RESET_PC || next_pc > HI_PC;
  end
endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: PC register, IF/ID pipeline register and RUN/HALTED/FAULT control
module if_fetch_unit
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int IM_WORDS = IM_WORDS_DEF,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [1:0]        redirect_kind,
  input  logic [31:0]       redirect_base,
  input  logic [25:0]       redirect_imm,
  input  logic [31:0]       redirect_reg,
  input  logic              halt_req,
  output logic [ADDR_W-1:0] im_addr,
  input  logic [31:0]       im_data,
  output logic [31:0]       ifid_instr,
  output logic [31:0]       ifid_pc,
  output logic              ifid_valid,
  output logic [31:0]       pc,
  output logic              halted,
  output logic              fault
);
  state_e state_q, state_d;
  logic [31:0] pc_q, pc_d, instr_q, instr_d, ipc_q, ipc_d, npc;
  logic valid_q, valid_d, illegal;
  if_next_pc #(.RESET_PC(RESET_PC), .IM_WORDS(IM_WORDS)) u_npc (
    .pc(pc_q), .redirect_valid(redirect_valid), .redirect_kind(redirect_kind),
    .redirect_base(redirect_base), .redirect_imm(redirect_imm),
    .redirect_reg(redirect_reg), .next_pc(npc), .illegal(illegal)
  );
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    instr_d = instr_q;
    ipc_d = ipc_q;
    valid_d = 1'b0;
    if (state_q == S_RUN) begin
      if (halt_req) state_d = S_HALTED;
      else if (redirect_valid) begin
        if (illegal) state_d = S_FAULT;
        else pc_d = npc;
      end else if (stall) valid_d = valid_q;
      else begin
        instr_d = im_data;
        ipc_d = pc_q;
        valid_d = 1'b1;
        if (illegal) state_d = S_FAULT;
        else pc_d = npc;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RUN;
      pc_q <= RESET_PC;
      instr_q <= '0;
      ipc_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      instr_q <= instr_d;
      ipc_q <= ipc_d;
      valid_q <= valid_d;
    end
  end
  assign im_addr = pc_q[ADDR_W-1:0];
  assign pc = pc_q;
  assign ifid_instr = instr_q;
  assign ifid_pc = ipc_q;
  assign ifid_valid = valid_q;
  assign halted = state_q == S_HALTED;
  assign fault = state_q == S_FAULT;
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed vectors against hand-computed fetch results
module tb_if_fetch_unit;
  logic clk = 1'b0, rst_n, stall, redirect_valid, halt_req;
  logic [1:0] redirect_kind;
  logic [31:0] redirect_base, redirect_reg, im_data, ifid_instr, ifid_pc, pc;
  logic [25:0] redirect_imm;
  logic [11:0] im_addr;
  logic ifid_valid, halted, fault;
  logic [31:0] mem [1024];
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  assign im_data = mem[im_addr[11:2]];
  if_fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_kind(redirect_kind), .redirect_base(redirect_base),
    .redirect_imm(redirect_imm), .redirect_reg(redirect_reg), .halt_req(halt_req),
    .im_addr(im_addr), .im_data(im_data), .ifid_instr(ifid_instr), .ifid_pc(ifid_pc),
    .ifid_valid(ifid_valid), .pc(pc), .halted(halted), .fault(fault)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(negedge clk);
  endtask
  task automatic idle;
    stall = 0; redirect_valid = 0; halt_req = 0; redirect_kind = 2'b00;
    redirect_base = 0; redirect_imm = 0; redirect_reg = 0;
  endtask
  task automatic redir(input logic [1:0] k, input logic [31:0] b, input logic [25:0] i,
                       input logic [31:0] r);
    redirect_valid = 1; redirect_kind = k; redirect_base = b; redirect_imm = i; redirect_reg = r;
    tick;
    idle;
  endtask
  task automatic do_reset;
    @(negedge clk);
    rst_n = 0;
    #2;
    rst_n = 1;
  endtask
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'hA000_0000 | i;
    mem[0] = 32'h2011_0001;
    mem[1] = 32'h0800_0c05;
    idle;
    rst_n = 0;
    repeat (2) tick;
    chk("rst_pc", pc, 32'h3000);
    chk("rst_instr", ifid_instr, 0);
    chk("rst_ipc", ifid_pc, 0);
    chk("rst_valid", {31'b0, ifid_valid}, 0);
    chk("rst_halted", {31'b0, halted}, 0);
    chk("rst_fault", {31'b0, fault}, 0);
    rst_n = 1;
    tick;
    chk("e1_instr", ifid_instr, 32'h2011_0001);
    chk("e1_ipc", ifid_pc, 32'h3000);
    chk("e1_valid", {31'b0, ifid_valid}, 1);
    chk("e1_pc", pc, 32'h3004);
    chk("e1_addr", {20'b0, im_addr}, 32'h004);
    redir(2'b01, 32'h3004, 26'h000c05, 0);
    chk("jmp_pc", pc, 32'h3014);
    chk("jmp_flush", {31'b0, ifid_valid}, 0);
    tick;
    chk("jmp_ipc", ifid_pc, 32'h3014);
    chk("jmp_valid", {31'b0, ifid_valid}, 1);
    chk("jmp_instr", ifid_instr, 32'hA000_0005);
    chk("jmp_seq", pc, 32'h3018);
    redir(2'b00, 32'h3064, 26'h0001, 0);
    chk("br_fwd", pc, 32'h306C);
    stall = 1;
    redir(2'b00, 32'h3168, 26'hFFF9, 0);
    chk("br_back_stall", pc, 32'h3150);
    chk("br_flush", {31'b0, ifid_valid}, 0);
    redir(2'b10, 0, 0, 32'h300C);
    chk("jr_300c", pc, 32'h300C);
    tick;
    chk("pre_stall_pc", pc, 32'h3010);
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("stall_pc", pc, 32'h3010);
      chk("stall_instr", ifid_instr, 32'hA000_0003);
      chk("stall_valid", {31'b0, ifid_valid}, 1);
    end
    stall = 0;
    tick;
    chk("resume_ipc", ifid_pc, 32'h3010);
    chk("resume_pc", pc, 32'h3014);
    redir(2'b10, 0, 0, 32'h3048);
    chk("jr_pc", pc, 32'h3048);
    redir(2'b10, 0, 0, 32'h3046);
    chk("jr_mis_fault", {31'b0, fault}, 1);
    chk("jr_mis_pc", pc, 32'h3048);
    tick;
    chk("fault_sticky", {31'b0, fault}, 1);
    chk("fault_valid", {31'b0, ifid_valid}, 0);
    chk("fault_pc", pc, 32'h3048);
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("async_rst_pc", pc, 32'h3000);
    chk("async_rst_fault", {31'b0, fault}, 0);
    rst_n = 1;
    redir(2'b10, 0, 0, 32'h3FF8);
    chk("to_edge_pc", pc, 32'h3FF8);
    tick;
    chk("edge_m1_pc", pc, 32'h3FFC);
    chk("edge_m1_fault", {31'b0, fault}, 0);
    tick;
    chk("edge_ipc", ifid_pc, 32'h3FFC);
    chk("edge_instr", ifid_instr, 32'hA000_03FF);
    chk("edge_valid", {31'b0, ifid_valid}, 1);
    chk("edge_fault", {31'b0, fault}, 1);
    chk("edge_pc", pc, 32'h3FFC);
    tick;
    chk("edge_after_valid", {31'b0, ifid_valid}, 0);
    do_reset;
    redir(2'b01, 32'h3000, 26'h0000BFF, 0);
    chk("jmp_low_fault", {31'b0, fault}, 1);
    chk("jmp_low_pc", pc, 32'h3000);
    do_reset;
    redir(2'b11, 32'h3000, 0, 32'h3008);
    chk("rk11_fault", {31'b0, fault}, 1);
    do_reset;
    tick;
    halt_req = 1;
    redir(2'b01, 32'h3004, 26'h000c05, 0);
    chk("halt_flag", {31'b0, halted}, 1);
    chk("halt_pc", pc, 32'h3004);
    chk("halt_valid", {31'b0, ifid_valid}, 0);
    repeat (2) tick;
    chk("halt_sticky", {31'b0, halted}, 1);
    chk("halt_hold_pc", pc, 32'h3004);
    chk("halt_hold_valid", {31'b0, ifid_valid}, 0);
    #2 rst_n = 0;
    #1;
    chk("halt_rst_pc", pc, 32'h3000);
    chk("halt_rst_flag", {31'b0, halted}, 0);
    rst_n = 1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
